// File: rtl/vga_sprite_compositor.sv
// vga_sprite_compositor
// VGA back end. It generates the raster timing and walks the background frame
// buffer with an incremental address. Up to NUM_SPRITES solid-colour rectangles
// are composited over the background stream; the lowest sprite index wins.
// Sprite registers are shadowed once per frame at the start of vertical blanking.
// Output pins lag the raster counters by BG_LAT+1 clocks.
// Optional feature macro: SPRITE_COLLISION_EN (sprite 0 vs sprite i overlap flags).
module vga_sprite_compositor #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int NUM_SPRITES = 4,
    parameter int SPR_W       = 32,
    parameter int SPR_H       = 32,
    parameter int BG_LAT      = 2
) (
    input  logic                      iVGA_CLK,
    input  logic                      iRST_n,
    input  logic [NUM_SPRITES*10-1:0] spr_x,
    input  logic [NUM_SPRITES*9-1:0]  spr_y,
    input  logic [NUM_SPRITES*24-1:0] spr_color,
    input  logic [NUM_SPRITES-1:0]    spr_en,
    output logic [18:0]               bg_addr,
    input  logic [23:0]               bg_data,
    output logic                      oHS,
    output logic                      oVS,
    output logic                      oBLANK_n,
    output logic [7:0]                b_data,
    output logic [7:0]                g_data,
    output logic [7:0]                r_data,
    output logic                      frame_start,
    output logic [NUM_SPRITES-2:0]    collision
);

    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] H_LAST   = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0]  V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [18:0] PIX_LAST = 19'(H_ACTIVE * V_ACTIVE - 1);
    localparam logic [10:0] SW       = 11'(SPR_W);
    localparam logic [9:0]  SH       = 10'(SPR_H);

    // One pixel's worth of everything that must travel alongside bg_data.
    // hs/vs are stored active-high ("in sync pulse") so a cleared stage reads as idle.
    typedef struct packed {
        logic        vis;
        logic        hs;
        logic        vs;
        logic        hit;
        logic [23:0] color;
    } pix_t;

    logic [10:0] h_cnt;
    logic [9:0]  v_cnt;
    logic        visible;
    logic        latch;
    logic        frame_wrap;

    logic [NUM_SPRITES*10-1:0] sh_x;
    logic [NUM_SPRITES*9-1:0]  sh_y;
    logic [NUM_SPRITES*24-1:0] sh_color;
    logic [NUM_SPRITES-1:0]    sh_en;

    logic [NUM_SPRITES-1:0] hit;
    pix_t                   stage0;
    pix_t                   pipe [BG_LAT];

    assign visible    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign latch      = (h_cnt == 11'd0) && (v_cnt == V_ACT);
    assign frame_wrap = (h_cnt == H_LAST) && (v_cnt == V_LAST);

    // Raster counters: h_cnt runs every clock, v_cnt advances on line wrap.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!iRST_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 11'd1;
        end
    end

    // Background address tracks the current pixel; saturates at the last pixel.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n)
            bg_addr <= '0;
        else if (frame_wrap)
            bg_addr <= '0;
        else if (visible && (bg_addr != PIX_LAST))
            bg_addr <= bg_addr + 19'd1;
    end

    // Shadow sprite registers, captured once per frame at the start of vertical blanking.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            sh_x        <= '0;
            sh_y        <= '0;
            sh_color    <= '0;
            sh_en       <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= latch;
            if (latch) begin
                sh_x     <= spr_x;
                sh_y     <= spr_y;
                sh_color <= spr_color;
                sh_en    <= spr_en;
            end
        end
    end

    // Per-sprite hit test and priority select; widened compares clip at the edges rather than wrap.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path infers a latch.
        hit    = '0;
        stage0 = '0;
        stage0.vis = visible;
        stage0.hs  = (h_cnt >= HS_START) && (h_cnt < HS_END);
        stage0.vs  = (v_cnt >= VS_START) && (v_cnt < VS_END);
        // Walk from the highest index down so the lowest hitting index overwrites last.
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            hit[i] = sh_en[i]
                  && (h_cnt >= {1'b0, sh_x[10*i +: 10]})
                  && (h_cnt <  {1'b0, sh_x[10*i +: 10]} + SW)
                  && (v_cnt >= {1'b0, sh_y[9*i +: 9]})
                  && (v_cnt <  {1'b0, sh_y[9*i +: 9]} + SH);
            if (hit[i]) begin
                stage0.hit   = 1'b1;
                stage0.color = sh_color[24*i +: 24];
            end
        end
    end

    // Delay line that aligns pixel attributes with the background read latency.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        // NOTE: these are pipeline flops, not a RAM; clearing them keeps stale pixels from escaping after reset.
        if (!iRST_n) begin
            for (int i = 0; i < BG_LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= stage0;
            for (int i = 1; i < BG_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    // Output register: composite and blank, then drive the DAC and sync pins.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            oHS      <= 1'b1;
            oVS      <= 1'b1;
            oBLANK_n <= 1'b0;
            b_data   <= '0;
            g_data   <= '0;
            r_data   <= '0;
        end else begin
            oHS      <= ~pipe[BG_LAT-1].hs;
            oVS      <= ~pipe[BG_LAT-1].vs;
            oBLANK_n <= pipe[BG_LAT-1].vis;
            if (!pipe[BG_LAT-1].vis)
                {b_data, g_data, r_data} <= 24'd0;
            else if (pipe[BG_LAT-1].hit)
                {b_data, g_data, r_data} <= pipe[BG_LAT-1].color;
            else
                {b_data, g_data, r_data} <= bg_data;
        end
    end

`ifdef SPRITE_COLLISION_EN
    logic [NUM_SPRITES-2:0] coll_acc;

    // Accumulate sprite-0 overlaps over the visible frame; publish and clear at the shadow latch.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            coll_acc  <= '0;
            collision <= '0;
        end else if (latch) begin
            collision <= coll_acc;
            coll_acc  <= '0;
        end else if (visible && hit[0]) begin
            coll_acc <= coll_acc | hit[NUM_SPRITES-1:1];
        end
    end
`else
    assign collision = '0;
`endif

endmodule

// File: tb/tb_vga_sprite_compositor.sv
// tb_vga_sprite_compositor
// Directed bench. A shrunk raster (80x56 total, 64x48 visible, 8x8 sprites)
// keeps frames short. A default-parameter instance checks the standard
// 640x480 line timing. Background data is a known function of address,
// delayed BG_LAT clocks like an external ROM.
module tb_vga_sprite_compositor;

    localparam int BG_LAT = 2;
    localparam int HT     = 80;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [39:0] spr_x;
    logic [35:0] spr_y;
    logic [95:0] spr_color;
    logic [3:0]  spr_en;
    logic [18:0] bg_addr;
    logic [23:0] bg_data, bg_d1, bg_d2;
    logic        o_hs, o_vs, o_blank_n, frame_start;
    logic [7:0]  b_data, g_data, r_data;
    logic [2:0]  collision;

    logic [18:0] d_addr;
    logic        d_hs, d_vs, d_blank_n, d_fs;
    logic [7:0]  d_b, d_g, d_r;
    logic [2:0]  d_coll;

    int n_checks = 0;
    int n_errors = 0;
    int edge_cnt;

    always #5 clk = ~clk;

    vga_sprite_compositor #(
        .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(4),
        .NUM_SPRITES(4), .SPR_W(8), .SPR_H(8), .BG_LAT(BG_LAT)
    ) u_dut (
        .iVGA_CLK(clk), .iRST_n(rst_n),
        .spr_x(spr_x), .spr_y(spr_y), .spr_color(spr_color), .spr_en(spr_en),
        .bg_addr(bg_addr), .bg_data(bg_data),
        .oHS(o_hs), .oVS(o_vs), .oBLANK_n(o_blank_n),
        .b_data(b_data), .g_data(g_data), .r_data(r_data),
        .frame_start(frame_start), .collision(collision)
    );

    vga_sprite_compositor u_def (
        .iVGA_CLK(clk), .iRST_n(rst_n),
        .spr_x(40'd0), .spr_y(36'd0), .spr_color(96'd0), .spr_en(4'd0),
        .bg_addr(d_addr), .bg_data(24'd0),
        .oHS(d_hs), .oVS(d_vs), .oBLANK_n(d_blank_n),
        .b_data(d_b), .g_data(d_g), .r_data(d_r),
        .frame_start(d_fs), .collision(d_coll)
    );

    function automatic logic [23:0] rom(input logic [18:0] a);
        return {5'b10101, a};
    endfunction

    // External background ROM model with BG_LAT (=2) clocks of latency.
    always @(posedge clk) begin
        bg_d1 <= rom(bg_addr);
        bg_d2 <= bg_d1;
    end
    assign bg_data = bg_d2;

    // Edges since the last reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic at_edge(input int t);
        while (edge_cnt < t) @(negedge clk);
    endtask

    // Sample output pixel (x,y) of the frame that follows frame_start seen at edge fs.
    task automatic px(input int fs, input int x, input int y);
        at_edge(fs + 639 + BG_LAT + 1 + y * HT + x);
    endtask

    task automatic wait_fs(output int fs);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 6000);
        if (!frame_start) check("frame_start_timeout", 32'(n), 32'd4480);
        fs = edge_cnt;
    endtask

    task automatic set_spr(input int i, input int x, input int y, input logic [23:0] c, input logic en);
        spr_x[10*i +: 10]     = 10'(x);
        spr_y[9*i +: 9]       = 9'(y);
        spr_color[24*i +: 24] = c;
        spr_en[i]             = en;
    endtask

    function automatic logic [23:0] pix();
        return {b_data, g_data, r_data};
    endfunction

    initial begin
        int  f1, f2, f3, f4, f5;
        int  hs_f1, hs_f2, blank_cnt, e;
        logic prev_hs;
        logic [2:0] coll_exp;
`ifdef SPRITE_COLLISION_EN
        coll_exp = 3'b010;
`else
        coll_exp = 3'b000;
`endif
        rst_n     = 1'b0;
        spr_x     = '0;
        spr_y     = '0;
        spr_color = '0;
        spr_en    = '0;
        set_spr(0, 0, 0, 24'h0000FF, 1'b1);
        set_spr(1, 56, 44, 24'h00FF00, 1'b1);
        set_spr(3, 60, 20, 24'hFFFFFF, 1'b1);
        repeat (3) @(negedge clk);
        check("rst_hs", o_hs, 1);
        check("rst_vs", o_vs, 1);
        check("rst_blank", o_blank_n, 0);
        check("rst_rgb", pix(), 0);
        check("rst_addr", bg_addr, 0);
        check("rst_fs", frame_start, 0);
        rst_n = 1'b1;

        // First lines: default-instance line timing and small-instance first pixel.
        hs_f1 = 0; hs_f2 = 0; blank_cnt = 0; prev_hs = 1'b1;
        while (edge_cnt < 1500) begin
            @(negedge clk);
            e = edge_cnt;
            if (e == 2)  check("first_blank_lo", o_blank_n, 0);
            if (e == 3)  check("first_blank_hi", o_blank_n, 1);
            if (e == 3)  check("first_pix", pix(), rom(0));
            if (e == 66) check("line_end_vis", o_blank_n, 1);
            if (e == 67) check("line_end_blank", o_blank_n, 0);
            if (e >= 3 && e <= 802 && d_blank_n) blank_cnt++;
            if (prev_hs && !d_hs) begin
                if (hs_f1 == 0) hs_f1 = e;
                else if (hs_f2 == 0) hs_f2 = e;
            end
            prev_hs = d_hs;
        end
        check("def_hs_first_fall", hs_f1, 659);
        check("def_line_period", hs_f2 - hs_f1, 800);
        check("def_blank_per_line", blank_cnt, 640);

        // Frame 0 latch, then vertical sync position.
        wait_fs(f1);
        check("fs_first_edge", f1, 3841);
        at_edge(4002);
        check("vs_before", o_vs, 1);
        at_edge(4003);
        check("vs_fall", o_vs, 0);

        // Frame 1: sprites latched at f1.
        px(f1, 0, 0);   check("f1_spr0_00", pix(), 24'h0000FF);
        px(f1, 8, 0);   check("f1_bg_8_0", pix(), rom(8));
        px(f1, 10, 0);
        set_spr(0, 16, 0, 24'h0000FF, 1'b1);
        set_spr(2, 20, 4, 24'hFF0000, 1'b1);
        px(f1, 22, 6);  check("f1_spr2_not_yet", pix(), rom(406));
        px(f1, 7, 7);   check("f1_spr0_77_held", pix(), 24'h0000FF);
        px(f1, 0, 8);   check("f1_bg_0_8", pix(), rom(512));
        px(f1, 62, 20); check("f1_spr3", pix(), 24'hFFFFFF);
        px(f1, 66, 20); check("f1_blank_rgb", pix(), 0);
        check("f1_blank_flag", o_blank_n, 0);
        px(f1, 55, 44); check("f1_bg_55_44", pix(), rom(2871));
        px(f1, 56, 44); check("f1_spr1_clip_lo", pix(), 24'h00FF00);
        px(f1, 0, 45);  check("f1_no_wrap", pix(), rom(2880));
        at_edge(f1 + 639 + 47 * HT + 63);
        check("addr_last", bg_addr, 3071);
        at_edge(f1 + 639 + 47 * HT + 64);
        check("addr_hold", bg_addr, 3071);
        px(f1, 63, 47); check("f1_spr1_corner", pix(), 24'h00FF00);

        // Frame 2: moved sprite 0, overlap with sprite 2.
        wait_fs(f2);
        check("frame_period", f2 - f1, 4480);
        check("coll_f2", collision, 0);
        px(f2, 0, 0);   check("f2_old_pos_bg", pix(), rom(0));
        px(f2, 16, 0);  check("f2_spr0_new", pix(), 24'h0000FF);
        px(f2, 21, 5);  check("f2_priority", pix(), 24'h0000FF);
        px(f2, 26, 9);  check("f2_spr2", pix(), 24'hFF0000);

        wait_fs(f3);
        check("coll_f3", collision, coll_exp);
        set_spr(2, 40, 30, 24'hFF0000, 1'b1);
        wait_fs(f4);
        check("coll_f4", collision, coll_exp);
        wait_fs(f5);
        check("coll_f5", collision, 0);

        // Reset in the middle of frame 5.
        px(f5, 10, 20); check("pre_rst_pix", pix(), rom(1290));
        rst_n = 1'b0;
        #1;
        check("mid_rst_blank", o_blank_n, 0);
        check("mid_rst_rgb", pix(), 0);
        check("mid_rst_addr", bg_addr, 0);
        check("mid_rst_hs", o_hs, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        at_edge(2);  check("re_blank_lo", o_blank_n, 0);
        at_edge(3);  check("re_first_pix", pix(), rom(0));
        at_edge(19); check("re_shadow_clr", pix(), rom(16));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
